// File: rtl/program_loader.sv
// Byte-stream program loader: packs bytes into little-endian words,
// writes them to memory and releases the CPU once the image is in.
module program_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        memwrite,
  output logic [31:0] memaddress,
  output logic [31:0] memdatain,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  localparam int unsigned WIW = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     bidx_q, bidx_d;
  logic [31:0]    asm_q, asm_d;
  logic [WIW-1:0] widx_q, widx_d;
  logic           last_q, last_d;
  logic           mw_q, mw_d;
  logic [31:0]    ma_q, ma_d;
  logic [31:0]    md_q, md_d;
  logic           hold_q, hold_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [31:0]    asm_next;

  // Lane insert; the register is zero between words so OR suffices.
  assign asm_next = asm_q
    | ({24'b0, in_byte} << {bidx_q, 3'b000});

  // Next-state, handshake and registered-output decode.
  always_comb begin
    state_d  = state_q;
    bidx_d   = bidx_q;
    asm_d    = asm_q;
    widx_d   = widx_q;
    last_d   = last_q;
    mw_d     = 1'b0;
    ma_d     = ma_q;
    md_d     = md_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    in_ready = (state_q == S_COLLECT)
            || (state_q == S_ERROR);
    unique case (state_q)
      S_COLLECT: begin
        if (in_valid) begin
          bidx_d = bidx_q + 2'd1;
          asm_d  = asm_next;
          if (bidx_q == 2'd3 || in_last) begin
            if (widx_q == WIW'(DEPTH_WORDS)) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end else begin
              state_d = S_WRITE;
              mw_d    = 1'b1;
              ma_d    = BASE_ADDR
                      + 32'({widx_q, 2'b00});
              md_d    = asm_next;
              last_d  = in_last;
            end
          end
        end
      end
      S_WRITE: begin
        widx_d = widx_q + 1'b1;
        asm_d  = 32'h0;
        bidx_d = 2'd0;
        if (cnt_q != 16'hFFFF)
          cnt_d = cnt_q + 16'd1;
        if (last_q) begin
          state_d = S_DONE;
          hold_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_COLLECT;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      bidx_q  <= 2'd0;
      asm_q   <= 32'h0;
      widx_q  <= '0;
      last_q  <= 1'b0;
      mw_q    <= 1'b0;
      ma_q    <= BASE_ADDR;
      md_q    <= 32'h0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      widx_q  <= widx_d;
      last_q  <= last_d;
      mw_q    <= mw_d;
      ma_q    <= ma_d;
      md_q    <= md_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign memwrite      = mw_q;
  assign memaddress    = ma_q;
  assign memdatain     = md_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign error         = err_q;
  assign words_written = cnt_q;

endmodule
